// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - multi-cycle FETCH/EXEC control unit for the BIP accumulator processor
//
// Purpose: owns the program counter, presents it to a synchronous program
// memory with a 1-cycle read latency, and decodes each fetched instruction
// into single-cycle datapath strobes. Every instruction takes two cycles.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   Instruction  program-memory read data (valid the cycle after Addr)
//   acc_zero     accumulator == 0, sampled by BEQ/BNE in their EXEC cycle
//   stall        freezes state, PC and counters; masks all strobes
//   Addr         registered PC presented to program memory
//   SelA         accumulator source: 0 data RAM, 1 immediate, 2 ALU
//   SelB         ALU operand B: 0 data RAM, 1 immediate
//   WrAcc        accumulator write strobe
//   Op           ALU operation: 0 add, 1 sub
//   WrRam        data-RAM write strobe
//   RdRam        data-RAM read strobe
//   Operand      instruction operand field during EXEC, 0 otherwise
//   halted       high in the HALT state
//   illegal      sticky undefined-opcode flag
//   retired      saturating count of executed instructions (HLT excluded)

module bip_control_unit #(
  parameter int B     = 16,
  parameter int W     = 11,
  parameter int OPW   = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [B-1:0]     Instruction,
  input  logic             acc_zero,
  input  logic             stall,
  output logic [W-1:0]     Addr,
  output logic [1:0]       SelA,
  output logic             SelB,
  output logic             WrAcc,
  output logic             Op,
  output logic             WrRam,
  output logic             RdRam,
  output logic [B-OPW-1:0] Operand,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int OW = B - OPW;

  localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] OP_STO  = OPW'(1);
  localparam logic [OPW-1:0] OP_LD   = OPW'(2);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(8);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(9);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(10);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(11);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   pc, pc_next;
  logic           illegal_hit;
  logic           retire;

  logic [OPW-1:0] opcode;
  logic [OW-1:0]  field;
  logic [W-1:0]   target;
  logic [W-1:0]   pc_inc;

  assign opcode = Instruction[B-1:B-OPW];
  assign field  = Instruction[OW-1:0];
  assign target = field[W-1:0];
  assign pc_inc = pc + W'(1);

  assign Addr   = pc;
  assign halted = (state == S_HALT);

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    illegal_hit = 1'b0;
    retire      = 1'b0;
    SelA        = 2'd0;
    SelB        = 1'b0;
    WrAcc       = 1'b0;
    Op          = 1'b0;
    WrRam       = 1'b0;
    RdRam       = 1'b0;
    Operand     = '0;

    case (state)
      S_FETCH: begin
        if (!stall) state_next = S_EXEC;
      end

      S_EXEC: begin
        Operand = field;
        // A stalled EXEC holds everything; the instruction stays on the
        // memory bus because Addr is unchanged, so it re-decodes on release.
        if (!stall) begin
          state_next = S_FETCH;
          pc_next    = pc_inc;
          retire     = 1'b1;
          case (opcode)
            OP_HLT: begin
              state_next = S_HALT;
              pc_next    = pc;
              retire     = 1'b0;
            end
            OP_STO:  WrRam = 1'b1;
            OP_LD:   begin RdRam = 1'b1; WrAcc = 1'b1; end
            OP_LDI:  begin SelA = 2'd1; WrAcc = 1'b1; end
            OP_ADD:  begin SelA = 2'd2; RdRam = 1'b1; WrAcc = 1'b1; end
            OP_ADDI: begin SelA = 2'd2; SelB = 1'b1; WrAcc = 1'b1; end
            OP_SUB:  begin SelA = 2'd2; Op = 1'b1; RdRam = 1'b1; WrAcc = 1'b1; end
            OP_SUBI: begin SelA = 2'd2; SelB = 1'b1; Op = 1'b1; WrAcc = 1'b1; end
            OP_JMP:  pc_next = target;
            OP_BEQ:  if (acc_zero)  pc_next = target;
            OP_BNE:  if (!acc_zero) pc_next = target;
            OP_NOP:  ;
            default: illegal_hit = 1'b1;
          endcase
        end
      end

      default: ;  // HALT: frozen until reset
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      illegal <= illegal | illegal_hit;
      if (retire && (retired != {CNT_W{1'b1}}))
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - randomized self-checking bench for bip_control_unit

module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Instruction;
  logic        acc_zero;
  logic        stall;
  logic [10:0] Addr;
  logic [1:0]  SelA;
  logic        SelB, WrAcc, Op, WrRam, RdRam;
  logic [10:0] Operand;
  logic        halted, illegal;
  logic [15:0] retired;

  bip_control_unit #(.B(16), .W(11), .OPW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .acc_zero(acc_zero),
    .stall(stall), .Addr(Addr), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
    .Op(Op), .WrRam(WrRam), .RdRam(RdRam), .Operand(Operand),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  always @(posedge clk) Instruction <= mem[Addr];

  logic [6:0] strobes;
  assign strobes = {SelA, SelB, WrAcc, Op, WrRam, RdRam};

  int tests_run = 0;
  int tests_failed = 0;

  // architectural model state
  logic [10:0] pc_m;
  logic [15:0] ret_m;
  logic        ill_m;
  logic        halted_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {SelA, SelB, WrAcc, Op, WrRam, RdRam} from the opcode table.
  function automatic logic [6:0] exp_strobes(input logic [4:0] opc);
    case (opc)
      5'd1:    return {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // STO
      5'd2:    return {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // LD
      5'd3:    return {2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // LDI
      5'd4:    return {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // ADD
      5'd5:    return {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // ADDI
      5'd6:    return {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // SUB
      5'd7:    return {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // SUBI
      default: return 7'd0;
    endcase
  endfunction

  task automatic model_reset();
    pc_m = '0; ret_m = '0; ill_m = 1'b0; halted_m = 1'b0;
  endtask

  // Execute one instruction at the current PC. Called at a negedge with the
  // DUT in FETCH; returns at the negedge of the following FETCH (or HALT).
  task automatic run_instr(input logic [15:0] instr, input logic az, input int nst);
    logic [4:0]  opc;
    logic [10:0] tgt;
    opc = instr[15:11];
    tgt = instr[10:0];
    mem[pc_m] = instr;
    check("fetch_addr", 32'(Addr), 32'(pc_m));
    check("fetch_strobes", 32'(strobes), 32'd0);
    check("fetch_operand", 32'(Operand), 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < nst; k++) begin
      stall = 1'b1;
      acc_zero = 1'($urandom);
      @(negedge clk);
      check("stall_strobes", 32'(strobes), 32'd0);
      check("stall_addr", 32'(Addr), 32'(pc_m));
      check("stall_retired", 32'(retired), 32'(ret_m));
      @(posedge clk); #1;
    end
    stall = 1'b0;
    acc_zero = az;
    @(negedge clk);
    check("exec_strobes", 32'(strobes), 32'(exp_strobes(opc)));
    check("exec_operand", 32'(Operand), 32'(tgt));

    if (opc == 5'd0) halted_m = 1'b1;
    else begin
      if (ret_m != 16'hFFFF) ret_m = ret_m + 16'd1;
      if (opc > 5'd11) ill_m = 1'b1;
      if (opc == 5'd8 || (opc == 5'd9 && az) || (opc == 5'd10 && !az)) pc_m = tgt;
      else pc_m = pc_m + 11'd1;
    end

    @(posedge clk); #1;
    @(negedge clk);
    check("post_addr", 32'(Addr), 32'(pc_m));
    check("post_retired", 32'(retired), 32'(ret_m));
    check("post_illegal", 32'(illegal), 32'(ill_m));
    check("post_halted", 32'(halted), 32'(halted_m));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] instr;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h5800;
    reset = 1'b0;
    stall = 1'b0;
    acc_zero = 1'b0;
    model_reset();
    #2;
    check("rst_addr", 32'(Addr), 32'd0);
    check("rst_strobes", 32'(strobes), 32'd0);
    check("rst_operand", 32'(Operand), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // directed: LDI, ADD, STO, branches, wrap, illegal, stall
    run_instr(16'h1805, 1'b0, 0);
    run_instr(16'h2003, 1'b0, 0);
    run_instr(16'h0807, 1'b0, 0);
    run_instr(16'h4820, 1'b1, 0);
    run_instr(16'h4820, 1'b0, 0);
    run_instr(16'h5020, 1'b1, 0);
    run_instr(16'h5020, 1'b0, 0);
    run_instr(16'h47FF, 1'b0, 0);
    run_instr(16'h5800, 1'b0, 0);
    run_instr(16'hF800, 1'b0, 0);
    run_instr(16'h1801, 1'b0, 0);
    run_instr(16'h5800, 1'b0, 0);
    run_instr(16'h0807, 1'b0, 3);

    // random programs with random stalls and branch conditions
    for (int n = 0; n < 300; n++) begin
      instr = {5'($urandom_range(1, 31)), 11'($urandom)};
      run_instr(instr, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // HLT freezes everything
    run_instr(16'h0000, 1'b0, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_addr", 32'(Addr), 32'(pc_m));
      check("halt_retired", 32'(retired), 32'(ret_m));
      check("halt_strobes", 32'(strobes), 32'd0);
    end

    do_reset();
    check("rerst_illegal", 32'(illegal), 32'd0);
    check("rerst_halted", 32'(halted), 32'd0);
    run_instr(16'h1805, 1'b0, 0);
    run_instr(16'h3809, 1'b0, 0);

    // reset asserted in the middle of an ADD EXEC
    mem[pc_m] = 16'h2003;
    @(posedge clk); #1;
    check("abort_pre_wracc", 32'(WrAcc), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_wracc", 32'(WrAcc), 32'd0);
    check("abort_strobes", 32'(strobes), 32'd0);
    check("abort_addr", 32'(Addr), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    run_instr(16'h1805, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Parametrised, multi-cycle control unit for the BIP accumulator processor. Generalises the fixed 16-bit/11-bit controller.
- Owns the program counter and drives the program-memory address. Decodes fetched instructions into datapath strobes.
- Adds conditional branches, a stall input, a HALT state, an illegal-opcode flag and a retired-instruction counter.
- Sits between the synchronous program memory (1-cycle read latency) and the accumulator/ALU/data-RAM datapath.

Parameters:
- B, 16, instruction width.
- W, 11, program-address width; must satisfy W <= B-OPW.
- OPW, 5, opcode width; the opcode is Instruction[B-1:B-OPW].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instruction  in  B  program-memory read data; valid the cycle after Addr is presented.
- acc_zero  in  1  accumulator == 0, from the datapath.
- stall  in  1  freeze request.
- Addr  out  W  program-memory address (registered PC).
- SelA  out  2  accumulator source select: 0 = data RAM, 1 = immediate, 2 = ALU.
- SelB  out  1  ALU operand B select: 0 = data RAM, 1 = immediate.
- WrAcc  out  1  accumulator write strobe.
- Op  out  1  ALU operation: 0 = add, 1 = sub.
- WrRam  out  1  data-RAM write strobe.
- RdRam  out  1  data-RAM read strobe.
- Operand  out  B-OPW  Instruction[B-OPW-1:0], driven during EXEC, 0 otherwise.
- halted  out  1  high while in the HALT state.
- illegal  out  1  sticky undefined-opcode flag.
- retired  out  CNT_W  count of executed instructions, saturating.

Behaviour:
- Reset (reset=0, async): state=FETCH, PC=0, illegal=0, retired=0. All strobes, SelA, SelB, Op and Operand are 0.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: Addr=PC is presented. Next state is EXEC. All strobes are 0.
  - EXEC: Instruction is decoded combinationally and strobes are asserted for exactly this cycle. At the clock edge, PC updates and the FSM returns to FETCH, or goes to HALT on HLT.
  - HALT: all strobes 0, PC frozen. Exit only via reset.
- Each instruction takes 2 cycles.
- Opcodes, strobes and next PC:
  - 00000 HLT: no strobes; next state HALT.
  - 00001 STO: WrRam=1.
  - 00010 LD: SelA=0, RdRam=1, WrAcc=1.
  - 00011 LDI: SelA=1, WrAcc=1.
  - 00100 ADD: SelA=2, SelB=0, Op=0, RdRam=1, WrAcc=1.
  - 00101 ADDI: SelA=2, SelB=1, Op=0, WrAcc=1.
  - 00110 SUB: as ADD with Op=1.
  - 00111 SUBI: as ADDI with Op=1.
  - 01000 JMP: PC <= Operand[W-1:0].
  - 01001 BEQ: PC <= Operand[W-1:0] if acc_zero, else PC+1.
  - 01010 BNE: PC <= Operand[W-1:0] if !acc_zero, else PC+1.
  - 01011 NOP: no strobes.
  - All other opcodes: treated as NOP; illegal <= 1 and stays set until reset.
  - Every instruction not listed as changing PC uses PC <= PC+1.
- PC arithmetic is modulo 2^W: PC=2^W-1 followed by +1 gives 0. Branch targets are truncated to W bits.
- Stall:
  - While stall=1, state, PC, retired and illegal hold, and all strobes are forced to 0.
  - An EXEC interrupted by stall re-asserts its strobes for one cycle on the first cycle after stall drops. There is no duplicate pulse.
  - acc_zero is sampled in that unstalled EXEC cycle.
- retired increments by 1 on each completed, unstalled EXEC except HLT. It saturates at 2^CNT_W-1.
- Reset asserted mid-EXEC aborts the instruction: no strobe survives the asynchronous reset edge.
- Addr, halted, illegal and retired are registered. SelA, SelB, WrAcc, Op, WrRam, RdRam and Operand are decoded from state and Instruction.

Test Plan:
Defaults B=16, W=11, OPW=5.
1. Reset low, then release; mem[0]=0x1805 (LDI 5). Required: Addr=0 in FETCH. Next cycle SelA=1, WrAcc=1, Operand=5. Then Addr=1, retired=1.
2. Sequence ADD 3 (0x2003) then STO 7 (0x0807).
   - ADD EXEC: SelA=2, SelB=0, Op=0, RdRam=1, WrAcc=1, Operand=3.
   - STO EXEC: WrRam=1 only, Operand=7.
3. BEQ 0x020 (0x4820) with acc_zero=1: next Addr=0x020. Same with acc_zero=0: Addr=PC+1. BNE (0x5020) gives the inverse results.
4. NOP (0x5800) at 0x7FF: next Addr=0x000. JMP 0x7FF (0x47FF): Addr=0x7FF. Opcode 0xF800: illegal=1, no strobes, illegal still 1 after two more instructions.
5. stall=1 for 3 cycles starting in the EXEC of STO: WrRam=0 throughout the stall. Exactly one WrRam pulse follows the stall. retired increments once.
6. HLT (0x0000): halted=1, Addr frozen, retired unchanged for 10 cycles. Separately, reset=0 mid-EXEC of ADD: WrAcc drops immediately, Addr=0, retired=0.
